// File: rtl/int_inject_pkg.sv
// Shared types and helpers for the interrupt-injection controller: channel
// state encoding, acknowledge address defaults and the acknowledge decode.
package int_inject_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_DELAY    = 3'd2,
        ST_ASSERTED = 3'd3,
        ST_COOLDOWN = 3'd4,
        ST_DONE     = 3'd5
    } ch_state_e;

    localparam logic [31:0] DEFAULT_ACK_ADDR = 32'h0000_7F20;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    // Any byte lane written anywhere inside the acknowledge word counts.
    function automatic logic is_ack(input logic [31:0] addr,
                                    input logic [3:0]  byteen,
                                    input logic [31:0] ack_addr);
        return (|byteen) && ((addr & WORD_MASK) == (ack_addr & WORD_MASK));
    endfunction

endpackage

// File: rtl/int_inject_channel.sv
// One injection channel: arms on a trigger PC, waits a programmable delay,
// holds its interrupt until acknowledged, then re-arms or finishes.
module int_inject_channel
    import int_inject_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DLY_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [31:0]      cfg_pc,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [31:0]      pc,
    input  logic             ack,
    output logic             asserted,
    output logic             fire,
    output logic             timeout_hit,
    output ch_state_e        state
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    ch_state_e        state_q, state_d;
    logic [31:0]      trig_pc_q;
    logic [CNT_W-1:0] remaining_q;
    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] dcnt_q;
    logic [TMR_W-1:0] timer_q;
    logic             asserted_q;

    logic             pc_match;
    logic             unlimited;
    logic [CNT_W-1:0] rem_dec;
    logic             staying_asserted;

    assign pc_match  = ((pc & WORD_MASK) == trig_pc_q);
    assign unlimited = &remaining_q;
    assign rem_dec   = remaining_q - CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    // A configuration write overrides every other event on this channel.
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = (cfg_count != '0) ? ST_ARMED : ST_DISABLED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (pc_match) state_d = (dly_q == '0) ? ST_ASSERTED : ST_DELAY;
                end
                ST_DELAY: begin
                    if (dcnt_q == DLY_W'(1)) state_d = ST_ASSERTED;
                end
                ST_ASSERTED: begin
                    if (ack) state_d = (unlimited || rem_dec != '0) ? ST_COOLDOWN : ST_DONE;
                end
                ST_COOLDOWN: begin
                    if (!pc_match) state_d = ST_ARMED;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        staying_asserted = (state_q == ST_ASSERTED) && (state_d == ST_ASSERTED);
        fire             = (state_d == ST_ASSERTED) && (state_q != ST_ASSERTED);
        timeout_hit      = (TIMEOUT != 0) && staying_asserted && (timer_q == TMR_LAST);
        asserted         = asserted_q;
        state            = state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_pc_q   <= '0;
            remaining_q <= '0;
            dly_q       <= '0;
            dcnt_q      <= '0;
            timer_q     <= '0;
            asserted_q  <= 1'b0;
        end else begin
            if (cfg_load) begin
                trig_pc_q   <= cfg_pc & WORD_MASK;
                remaining_q <= cfg_count;
                dly_q       <= cfg_delay;
            end else if (state_q == ST_ASSERTED && ack && !unlimited) begin
                remaining_q <= rem_dec;
            end

            if (state_d == ST_DELAY) begin
                dcnt_q <= (state_q == ST_DELAY) ? dcnt_q - DLY_W'(1) : dly_q;
            end else begin
                dcnt_q <= '0;
            end

            // Timer holds at its last value; the sticky error lives in the top.
            if (staying_asserted) begin
                if (timer_q != TMR_LAST) timer_q <= timer_q + TMR_W'(1);
            end else begin
                timer_q <= '0;
            end

            asserted_q <= (state_d == ST_ASSERTED);
        end
    end

endmodule

// File: rtl/int_inject_ctrl.sv
// Multi-channel interrupt-injection controller: watches the CPU PC and the
// interrupt-space store bus, and drives the CPU interrupt input.
module int_inject_ctrl
    import int_inject_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 8,
    parameter int          DLY_W    = 8,
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ACK_ADDR = DEFAULT_ACK_ADDR,
    localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             macroscopic_pc,
    input  logic [31:0]             m_int_addr,
    input  logic [3:0]              m_int_byteen,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [31:0]             cfg_pc,
    input  logic [CNT_W-1:0]        cfg_count,
    input  logic [DLY_W-1:0]        cfg_delay,
    output logic                    interrupt,
    output logic [NUM_CH-1:0]       int_vec,
    output logic                    timeout_err,
    output logic [15:0]             fire_total,
    output ch_state_e [NUM_CH-1:0]  ch_state
);

    logic              ack;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] tmo_hit;
    logic [4:0]        fire_cnt;
    logic [16:0]       fire_sum;
    logic [15:0]       fire_total_d;

    assign ack = is_ack(m_int_addr, m_int_byteen, ACK_ADDR);

    // Indices at or beyond NUM_CH match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic cfg_load;
        assign cfg_load = cfg_we && (cfg_ch == CH_W'(i));

        int_inject_channel #(
            .CNT_W   (CNT_W),
            .DLY_W   (DLY_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .cfg_load    (cfg_load),
            .cfg_pc      (cfg_pc),
            .cfg_count   (cfg_count),
            .cfg_delay   (cfg_delay),
            .pc          (macroscopic_pc),
            .ack         (ack),
            .asserted    (int_vec[i]),
            .fire        (fire[i]),
            .timeout_hit (tmo_hit[i]),
            .state       (ch_state[i])
        );
    end

    assign interrupt = |int_vec;

    always_comb begin
        fire_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fire_cnt = fire_cnt + 5'(fire[i]);
        end
        fire_sum     = {1'b0, fire_total} + {12'd0, fire_cnt};
        fire_total_d = fire_sum[16] ? 16'hFFFF : fire_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fire_total  <= '0;
            timeout_err <= 1'b0;
        end else begin
            fire_total <= fire_total_d;
            if (|tmo_hit) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_int_inject_ctrl.sv
// Randomised and directed bench for int_inject_ctrl with a per-cycle
// behavioural model feeding an expected-value queue.
module tb_int_inject_ctrl;
    import int_inject_pkg::*;

    localparam int          NUM_CH   = 4;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ACK_A    = 32'h0000_7F20;
    localparam logic [31:0] IDLE_PC  = 32'h0000_3100;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [31:0]            macroscopic_pc = IDLE_PC;
    logic [31:0]            m_int_addr = '0;
    logic [3:0]             m_int_byteen = '0;
    logic                   cfg_we = 1'b0;
    logic [1:0]             cfg_ch = '0;
    logic [31:0]            cfg_pc = '0;
    logic [7:0]             cfg_count = '0;
    logic [7:0]             cfg_delay = '0;
    logic                   interrupt;
    logic [NUM_CH-1:0]      int_vec;
    logic                   timeout_err;
    logic [15:0]            fire_total;
    ch_state_e [NUM_CH-1:0] ch_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {int_vec, interrupt, timeout_err, fire_total, done_mask}
    logic [25:0] exp_q[$];

    int_inject_ctrl #(
        .NUM_CH(NUM_CH), .CNT_W(8), .DLY_W(8), .TIMEOUT(TIMEOUT), .ACK_ADDR(ACK_A)
    ) dut (
        .clk(clk), .reset(reset), .macroscopic_pc(macroscopic_pc),
        .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pc(cfg_pc),
        .cfg_count(cfg_count), .cfg_delay(cfg_delay),
        .interrupt(interrupt), .int_vec(int_vec), .timeout_err(timeout_err),
        .fire_total(fire_total), .ch_state(ch_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int {M_OFF, M_WAIT_PC, M_COUNTING, M_ON, M_HOLD_OFF, M_FINISHED} mphase_e;
    mphase_e     m_phase[NUM_CH];
    logic [31:0] m_trig[NUM_CH];
    int          m_left[NUM_CH];
    bit          m_unl[NUM_CH];
    int          m_dly[NUM_CH];
    int          m_wait[NUM_CH];
    int          m_on[NUM_CH];
    int          m_total;
    bit          m_tmo;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_phase[c] = M_OFF; m_trig[c] = '0; m_left[c] = 0; m_unl[c] = 0;
            m_dly[c] = 0; m_wait[c] = 0; m_on[c] = 0;
        end
        m_total = 0;
        m_tmo   = 0;
    endtask

    task automatic model_step(input logic [31:0] pc, input logic [31:0] addr, input logic [3:0] be,
                              input logic we, input int ch, input logic [31:0] cpc,
                              input int cnt, input int dly);
        bit          ack_hit;
        bit          at_trig;
        int          fires;
        logic [3:0]  vec;
        logic [3:0]  done;
        ack_hit = (be != 4'h0) && ((addr >> 2) == (ACK_A >> 2));
        fires   = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            at_trig = ((pc >> 2) == (m_trig[c] >> 2));
            if (we && ch == c) begin
                m_trig[c]  = cpc;
                m_left[c]  = cnt;
                m_unl[c]   = (cnt == 255);
                m_dly[c]   = dly;
                m_on[c]    = 0;
                m_phase[c] = (cnt != 0) ? M_WAIT_PC : M_OFF;
            end else begin
                case (m_phase[c])
                    M_WAIT_PC: if (at_trig) begin
                        if (m_dly[c] == 0) begin
                            m_phase[c] = M_ON; m_on[c] = 0; fires++;
                        end else begin
                            m_phase[c] = M_COUNTING; m_wait[c] = m_dly[c];
                        end
                    end
                    M_COUNTING: begin
                        m_wait[c]--;
                        if (m_wait[c] == 0) begin
                            m_phase[c] = M_ON; m_on[c] = 0; fires++;
                        end
                    end
                    M_ON: if (ack_hit) begin
                        if (!m_unl[c]) m_left[c]--;
                        m_phase[c] = (!m_unl[c] && m_left[c] == 0) ? M_FINISHED : M_HOLD_OFF;
                    end else begin
                        m_on[c]++;
                        if (TIMEOUT != 0 && m_on[c] >= TIMEOUT) m_tmo = 1;
                    end
                    M_HOLD_OFF: if (!at_trig) m_phase[c] = M_WAIT_PC;
                    default: ;
                endcase
            end
        end
        m_total = m_total + fires;
        if (m_total > 65535) m_total = 65535;
        for (int c = 0; c < NUM_CH; c++) begin
            vec[c]  = (m_phase[c] == M_ON);
            done[c] = (m_phase[c] == M_FINISHED);
        end
        exp_q.push_back({vec, |vec, m_tmo, 16'(m_total), done});
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin : monitor
        logic [25:0] e;
        logic [3:0]  dut_done;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int c = 0; c < NUM_CH; c++) dut_done[c] = (ch_state[c] == ST_DONE);
                check("int_vec",     32'(int_vec),     32'(e[25:22]));
                check("interrupt",   32'(interrupt),   32'(e[21]));
                check("timeout_err", 32'(timeout_err), 32'(e[20]));
                check("fire_total",  32'(fire_total),  32'(e[19:4]));
                check("done_mask",   32'(dut_done),    32'(e[3:0]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [31:0] pc, input logic [31:0] addr, input logic [3:0] be,
                         input logic we, input int ch, input logic [31:0] cpc,
                         input int cnt, input int dly);
        @(negedge clk);
        macroscopic_pc = pc;
        m_int_addr     = addr;
        m_int_byteen   = be;
        cfg_we         = we;
        cfg_ch         = 2'(ch);
        cfg_pc         = cpc;
        cfg_count      = 8'(cnt);
        cfg_delay      = 8'(dly);
        model_step(pc, addr, be, we, ch, cpc, cnt, dly);
    endtask

    task automatic go(input logic [31:0] pc);
        drive(pc, 32'h0, 4'h0, 1'b0, 0, 32'h0, 0, 0);
    endtask

    task automatic ack_at(input logic [31:0] pc, input logic [31:0] addr, input logic [3:0] be);
        drive(pc, addr, be, 1'b0, 0, 32'h0, 0, 0);
    endtask

    task automatic cfg(input int ch, input logic [31:0] cpc, input int cnt, input int dly);
        drive(IDLE_PC, 32'h0, 4'h0, 1'b1, ch, cpc, cnt, dly);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) go(IDLE_PC);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int cnt_tab[5];
        cnt_tab = '{0, 1, 2, 3, 255};
        model_reset();

        #12;
        check("reset_int_vec",     32'(int_vec),     32'h0);
        check("reset_interrupt",   32'(interrupt),   32'h0);
        check("reset_timeout_err", 32'(timeout_err), 32'h0);
        check("reset_fire_total",  32'(fire_total),  32'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        idle(2);

        // single fire, then revisit must not re-fire
        cfg(0, 32'h3010, 1, 0);
        go(32'h3010);
        idle(2);
        ack_at(IDLE_PC, ACK_A, 4'hF);
        idle(1);
        go(32'h3010); go(32'h3010);
        idle(2);

        // delayed assertion
        cfg(1, 32'h3020, 1, 5);
        go(32'h3020);
        idle(8);
        ack_at(IDLE_PC, ACK_A, 4'hF);
        idle(1);

        // repeat count with PC stalled across the ack
        cfg(2, 32'h3030, 3, 0);
        for (int r = 0; r < 4; r++) begin
            go(32'h3030);
            ack_at(32'h3030, ACK_A, 4'hF);
            go(32'h3030); go(32'h3030);
            idle(2);
        end

        // unlimited count
        cfg(2, 32'h3034, 255, 0);
        for (int r = 0; r < 300; r++) begin
            go(32'h3034);
            ack_at(IDLE_PC, ACK_A, 4'hF);
            go(IDLE_PC);
        end
        cfg(2, 32'h0, 0, 0);

        // shared trigger PC and ack address decode
        cfg(0, 32'h3040, 1, 0);
        cfg(3, 32'h3042, 2, 0);
        go(32'h3040);
        ack_at(IDLE_PC, 32'h7F24, 4'hF);
        ack_at(IDLE_PC, 32'h7F1C, 4'hF);
        ack_at(IDLE_PC, ACK_A, 4'h0);
        ack_at(IDLE_PC, 32'h7F22, 4'b0100);
        idle(2);

        // acked one cycle short of the timeout: no error
        cfg(3, 32'h3070, 1, 0);
        go(32'h3070);
        idle(TIMEOUT - 1);
        ack_at(IDLE_PC, ACK_A, 4'h1);
        idle(2);

        // randomised traffic
        for (int k = 0; k < 1500; k++) begin
            int          r;
            int          a;
            logic [31:0] pc;
            r  = $urandom_range(0, 99);
            a  = $urandom_range(0, 99);
            pc = 32'h3000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            if (r < 6) begin
                drive(pc, 32'h0, 4'h0, 1'b1, $urandom_range(0, NUM_CH - 1),
                      32'h3000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                      cnt_tab[$urandom_range(0, 4)], $urandom_range(0, 3));
            end else if (a < 50) begin
                ack_at(pc, ACK_A + 32'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
            end else if (a < 60) begin
                ack_at(pc, ($urandom_range(0, 1) != 0) ? 32'h7F24 : 32'h7F1C, 4'hF);
            end else if (a < 65) begin
                ack_at(pc, ACK_A, 4'h0);
            end else begin
                go(pc);
            end
        end
        for (int c = 0; c < NUM_CH; c++) cfg(c, 32'h0, 0, 0);
        idle(2);

        // timeout, sticky, then abort by reconfiguration
        cfg(0, 32'h3050, 2, 0);
        go(32'h3050);
        idle(TIMEOUT + 1);
        cfg(0, 32'h3050, 1, 0);
        @(posedge clk);
        #3;
        check("abort_armed", 32'(ch_state[0]), 32'(ST_ARMED));
        idle(3);

        // async reset with one channel mid-delay and one asserted
        cfg(1, 32'h3060, 1, 10);
        cfg(2, 32'h3064, 1, 0);
        go(32'h3060);
        go(32'h3064);
        go(IDLE_PC);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_int_vec",     32'(int_vec),     32'h0);
        check("async_interrupt",   32'(interrupt),   32'h0);
        check("async_timeout_err", 32'(timeout_err), 32'h0);
        check("async_fire_total",  32'(fire_total),  32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        for (int r = 0; r < 2; r++) begin
            go(32'h3060); go(32'h3064); go(32'h3050);
            go(32'h3010); go(32'h3040); go(32'h3070);
            ack_at(IDLE_PC, ACK_A, 4'hF);
        end
        idle(12);

        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
